// File: rtl/rggen_bus_arbiter.sv
// Round-robin arbiter that funnels HOSTS register-bus requesters onto one
// downstream bus, holding a registered copy of the winner's request per access.
module rggen_bus_arbiter #(
  parameter int unsigned ADDRESS_WIDTH = 8,
  parameter int unsigned BUS_WIDTH     = 32,
  parameter int unsigned HOSTS         = 2
) (
  input  logic                               i_clk,
  input  logic                               i_rst_n,
  input  logic [HOSTS-1:0]                   i_valid,
  input  logic [HOSTS*ADDRESS_WIDTH-1:0]     i_address,
  input  logic [HOSTS-1:0]                   i_write,
  input  logic [HOSTS*BUS_WIDTH-1:0]         i_write_data,
  input  logic [HOSTS*(BUS_WIDTH/8)-1:0]     i_strobe,
  output logic [HOSTS-1:0]                   o_ready,
  output logic [1:0]                         o_status,
  output logic [BUS_WIDTH-1:0]               o_read_data,
  output logic [HOSTS-1:0]                   o_grant,
  output logic                               o_bus_valid,
  output logic [ADDRESS_WIDTH-1:0]           o_bus_address,
  output logic                               o_bus_write,
  output logic [BUS_WIDTH-1:0]               o_bus_write_data,
  output logic [BUS_WIDTH/8-1:0]             o_bus_strobe,
  input  logic                               i_bus_ready,
  input  logic [1:0]                         i_bus_status,
  input  logic [BUS_WIDTH-1:0]               i_bus_read_data
);

  localparam int unsigned STRB_W = BUS_WIDTH / 8;
  localparam int unsigned IDX_W  = (HOSTS > 1) ? $clog2(HOSTS) : 1;

  typedef enum logic {
    IDLE,
    BUSY
  } state_e;

  state_e             state;
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   winner;
  logic [IDX_W-1:0]   pick;
  logic [IDX_W-1:0]   cand;
  logic               found;
  logic               take;

  // Round-robin search: first valid host at or after ptr, wrapping at HOSTS.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int i = 0; i < int'(HOSTS); i++) begin
      cand = IDX_W'((32'(ptr) + 32'(i)) % HOSTS);
      if (!found && i_valid[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  assign take = (state == IDLE) && found;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      ptr         <= '0;
      o_bus_valid <= 1'b0;
      o_grant     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            state       <= BUSY;
            o_bus_valid <= 1'b1;
            o_grant     <= HOSTS'(1) << pick;
          end
        end
        BUSY: begin
          if (i_bus_ready) begin
            state       <= IDLE;
            o_bus_valid <= 1'b0;
            o_grant     <= '0;
            ptr         <= IDX_W'((32'(winner) + 32'd1) % HOSTS);
          end
        end
        default: begin
          state       <= IDLE;
          o_bus_valid <= 1'b0;
          o_grant     <= '0;
        end
      endcase
    end
  end

  // Request snapshot; only meaningful while the access is in flight, so no reset.
  always_ff @(posedge i_clk) begin
    if (take) begin
      winner           <= pick;
      o_bus_address    <= i_address[32'(pick)*ADDRESS_WIDTH +: ADDRESS_WIDTH];
      o_bus_write      <= i_write[pick];
      o_bus_write_data <= i_write_data[32'(pick)*BUS_WIDTH +: BUS_WIDTH];
      o_bus_strobe     <= i_strobe[32'(pick)*STRB_W +: STRB_W];
    end
  end

  // Completion is passed straight through to the granted host in the ready cycle.
  assign o_ready     = i_bus_ready ? o_grant : '0;
  assign o_status    = i_bus_status;
  assign o_read_data = i_bus_read_data;

endmodule

// File: tb/tb_rggen_bus_arbiter.sv
// Self-checking bench for rggen_bus_arbiter (2 hosts) against a request-level
// arbitration model plus directed scenarios.
module tb_rggen_bus_arbiter;

  localparam int unsigned AW = 8;
  localparam int unsigned BW = 32;
  localparam int unsigned H  = 2;
  localparam int unsigned SW = BW / 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [H-1:0]      valid;
  logic [H*AW-1:0]   address;
  logic [H-1:0]      write;
  logic [H*BW-1:0]   write_data;
  logic [H*SW-1:0]   strobe;
  logic [H-1:0]      ready;
  logic [1:0]        status;
  logic [BW-1:0]     read_data;
  logic [H-1:0]      grant;
  logic              bus_valid;
  logic [AW-1:0]     bus_address;
  logic              bus_write;
  logic [BW-1:0]     bus_write_data;
  logic [SW-1:0]     bus_strobe;
  logic              bus_ready;
  logic [1:0]        bus_status;
  logic [BW-1:0]     bus_read_data;

  rggen_bus_arbiter #(.ADDRESS_WIDTH(AW), .BUS_WIDTH(BW), .HOSTS(H)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_valid(valid), .i_address(address), .i_write(write),
    .i_write_data(write_data), .i_strobe(strobe),
    .o_ready(ready), .o_status(status), .o_read_data(read_data),
    .o_grant(grant), .o_bus_valid(bus_valid), .o_bus_address(bus_address),
    .o_bus_write(bus_write), .o_bus_write_data(bus_write_data),
    .o_bus_strobe(bus_strobe), .i_bus_ready(bus_ready),
    .i_bus_status(bus_status), .i_bus_read_data(bus_read_data)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: one outstanding access, round-robin pointer.
  bit          m_busy;
  int          m_owner;
  int          m_ptr;
  logic [AW-1:0] m_addr;
  logic          m_write;
  logic [BW-1:0] m_wdata;
  logic [SW-1:0] m_strb;
  int          done_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic set_host(input int h, input bit v, input logic [AW-1:0] a,
                          input bit w, input logic [BW-1:0] d, input logic [SW-1:0] s);
    valid[h]               = v;
    address[h*AW +: AW]    = a;
    write[h]               = w;
    write_data[h*BW +: BW] = d;
    strobe[h*SW +: SW]     = s;
  endtask

  // Check one cycle against the model, then advance the model across the edge.
  task automatic step();
    logic [H-1:0] exp_ready;
    int h;
    bit hit;
    #1;
    check("bus_valid", 64'(bus_valid), 64'(m_busy));
    check("grant", 64'(grant), m_busy ? 64'(1) << m_owner : 64'd0);
    if (m_busy) begin
      check("bus_address", 64'(bus_address), 64'(m_addr));
      check("bus_write", 64'(bus_write), 64'(m_write));
      check("bus_write_data", 64'(bus_write_data), 64'(m_wdata));
      check("bus_strobe", 64'(bus_strobe), 64'(m_strb));
    end
    exp_ready = (m_busy && bus_ready) ? H'(1) << m_owner : '0;
    check("ready", 64'(ready), 64'(exp_ready));
    check("ready_onehot", 64'($countones(ready) <= 1), 64'd1);
    if (exp_ready != '0) begin
      check("status", 64'(status), 64'(bus_status));
      check("read_data", 64'(read_data), 64'(bus_read_data));
    end
    @(posedge clk);
    if (!m_busy) begin
      hit = 1'b0;
      for (int k = 0; k < int'(H); k++) begin
        h = (m_ptr + k) % H;
        if (!hit && valid[h]) begin
          hit     = 1'b1;
          m_busy  = 1'b1;
          m_owner = h;
          m_addr  = address[h*AW +: AW];
          m_write = write[h];
          m_wdata = write_data[h*BW +: BW];
          m_strb  = strobe[h*SW +: SW];
        end
      end
    end else if (bus_ready) begin
      done_q.push_back(m_owner);
      m_busy = 1'b0;
      m_ptr  = (m_owner + 1) % H;
    end
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    valid = '0; address = '0; write = '0; write_data = '0; strobe = '0;
    bus_ready = 1'b0; bus_status = '0; bus_read_data = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    m_busy = 1'b0;
    m_ptr  = 0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_bus_valid", 64'(bus_valid), 64'd0);
    check("rst_grant", 64'(grant), 64'd0);
    check("rst_ready", 64'(ready), 64'd0);
    rst_n = 1'b1;
  endtask

  task automatic drain();
    valid = '0;
    bus_ready = 1'b1;
    repeat (3) step();
    bus_ready = 1'b0;
  endtask

  initial begin
    do_reset();

    // Single read from host0, downstream ready two cycles after bus_valid.
    set_host(0, 1'b1, 8'h10, 1'b0, '0, '0);
    #1 check("sr_c0_valid", 64'(bus_valid), 64'd0);
    step();
    #1 check("sr_c1_valid", 64'(bus_valid), 64'd1);
    check("sr_c1_grant", 64'(grant), 64'd1);
    check("sr_c1_addr", 64'(bus_address), 64'h10);
    step();
    step();
    bus_ready = 1'b1; bus_read_data = 32'hA5A5A5A5; bus_status = 2'b00;
    #1 check("sr_c3_ready", 64'(ready), 64'b01);
    check("sr_c3_data", 64'(read_data), 64'hA5A5A5A5);
    step();
    valid = '0; bus_ready = 1'b0;
    #1 check("sr_c4_valid", 64'(bus_valid), 64'd0);
    step();

    // Both hosts continuously valid from reset: strict alternation.
    do_reset();
    done_q.delete();
    set_host(0, 1'b1, 8'h20, 1'b0, 32'h0, 4'h0);
    set_host(1, 1'b1, 8'h30, 1'b1, 32'hCAFE, 4'hF);
    for (int i = 0; i < 40; i++) begin
      bus_ready = 1'($urandom_range(0, 1));
      step();
    end
    check("alt_count_nonzero", 64'(done_q.size() >= 4), 64'd1);
    if (done_q.size() > 0) check("alt_first", 64'(done_q[0]), 64'd0);
    for (int i = 1; i < done_q.size(); i++)
      check("alt_order", 64'(done_q[i]), 64'(1 - done_q[i-1]));
    drain();

    // Field isolation: host1 write held while host0 churns its inputs.
    set_host(1, 1'b1, 8'h44, 1'b1, 32'h12345678, 4'b0011);
    step();
    for (int i = 0; i < 4; i++) begin
      set_host(0, 1'(i % 2), 8'($urandom), 1'($urandom), $urandom, 4'($urandom));
      if (i == 2) valid[1] = 1'b0;
      bus_ready = (i == 3);
      #1 check("iso_wdata", 64'(bus_write_data), 64'h12345678);
      check("iso_strobe", 64'(bus_strobe), 64'b0011);
      check("iso_addr", 64'(bus_address), 64'h44);
      check("iso_grant", 64'(grant), 64'b10);
      step();
    end
    drain();

    // Zero-latency downstream: bus_valid toggles every cycle.
    set_host(0, 1'b1, 8'h01, 1'b0, '0, '0);
    set_host(1, 1'b1, 8'h02, 1'b0, '0, '0);
    bus_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1 check("zl_valid", 64'(bus_valid), 64'(k % 2));
      step();
    end
    drain();

    // Error status on a host1 write.
    set_host(1, 1'b1, 8'h50, 1'b1, 32'hDEAD0001, 4'hF);
    step();
    bus_ready = 1'b1; bus_status = 2'b10;
    #1 check("err_status", 64'(status), 64'b10);
    check("err_ready", 64'(ready), 64'b10);
    step();
    drain();

    // Reset while busy aborts the access; host0 wins first after release.
    set_host(1, 1'b1, 8'h60, 1'b0, '0, '0);
    step();
    bus_ready = 1'b1;
    rst_n = 1'b0;
    #1 check("mid_rst_valid", 64'(bus_valid), 64'd0);
    check("mid_rst_ready", 64'(ready), 64'd0);
    check("mid_rst_grant", 64'(grant), 64'd0);
    m_busy = 1'b0;
    m_ptr  = 0;
    @(negedge clk);
    rst_n = 1'b1;
    bus_ready = 1'b0;
    set_host(0, 1'b1, 8'h70, 1'b0, '0, '0);
    set_host(1, 1'b1, 8'h71, 1'b0, '0, '0);
    step();
    #1 check("post_rst_grant", 64'(grant), 64'b01);
    step();
    drain();

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      for (int h = 0; h < int'(H); h++)
        set_host(h, 1'($urandom_range(0, 2) != 0), 8'($urandom), 1'($urandom),
                 $urandom, 4'($urandom));
      bus_ready     = ($urandom_range(0, 2) == 0);
      bus_status    = 2'($urandom);
      bus_read_data = $urandom;
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
